// File: rtl/sys_defs.sv
// +----------------------------------------------------------------------------+
// | sys_defs: shared machine-wide sizes and the CDB / FU completion records.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef FU_NUM
`define FU_NUM 4
`endif
`ifndef CDB_NUM
`define CDB_NUM 2
`endif
`ifndef TAG_IDX_WIDTH
`define TAG_IDX_WIDTH 6
`endif

package sys_defs;

    localparam int FU_NUM        = `FU_NUM;
    localparam int CDB_NUM       = `CDB_NUM;
    localparam int TAG_IDX_WIDTH = `TAG_IDX_WIDTH;

    typedef struct packed {
        logic                     valid;
        logic [TAG_IDX_WIDTH-1:0] tag;
    } CDB;

    typedef struct packed {
        logic                     valid;
        logic [TAG_IDX_WIDTH-1:0] tag;
    } FU_CDB;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
// +----------------------------------------------------------------------------+
// | rr_pick: scans requests upward from a start index, returns the first      |
// | C_CDB_NUM hits as one-hot vectors, one per broadcast channel.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
    parameter int C_FU_NUM  = 4,
    parameter int C_CDB_NUM = 2,
    parameter int C_PTR_W   = 2
) (
    input  logic [C_FU_NUM-1:0]                 i_req,
    input  logic [C_PTR_W-1:0]                  i_start,
    output logic [C_CDB_NUM-1:0][C_FU_NUM-1:0]  o_grant
);

    always_comb begin
        int w_cnt;
        int w_idx;
        o_grant = '0;
        w_cnt   = 0;
        w_idx   = 0;
        for (int off = 0; off < C_FU_NUM; off++) begin
            w_idx = int'(i_start) + off;
            if (w_idx >= C_FU_NUM) begin
                w_idx = w_idx - C_FU_NUM;
            end
            if (i_req[w_idx] && (w_cnt < C_CDB_NUM)) begin
                o_grant[w_cnt][w_idx] = 1'b1;
                w_cnt = w_cnt + 1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// +----------------------------------------------------------------------------+
// | cdb_arbiter: grants up to C_CDB_NUM FU completions per cycle onto the     |
// | registered CDB. CDB_ARB_RR_EN defined -> round-robin, else fixed priority.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdb_arbiter
    import sys_defs::*;
#(
    parameter int C_FU_NUM        = FU_NUM,
    parameter int C_CDB_NUM       = CDB_NUM,
    parameter int C_TAG_IDX_WIDTH = TAG_IDX_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         rollback_i,
    input  FU_CDB [C_FU_NUM-1:0]         fu_req_i,
    output logic  [C_FU_NUM-1:0]         fu_ack_o,
    output CDB    [C_CDB_NUM-1:0]        cdb_o
);

    localparam int C_PTR_W = (C_FU_NUM > 1) ? $clog2(C_FU_NUM) : 1;

    if (C_TAG_IDX_WIDTH != TAG_IDX_WIDTH) begin : g_tag_width_check
        $error("cdb_arbiter: C_TAG_IDX_WIDTH must match sys_defs TAG_IDX_WIDTH");
    end

    logic [C_FU_NUM-1:0]                w_req_valid;
    logic [C_PTR_W-1:0]                 w_start;
    logic [C_CDB_NUM-1:0][C_FU_NUM-1:0] w_grant;
    logic [C_FU_NUM-1:0]                w_ack;
    CDB   [C_CDB_NUM-1:0]               w_cdb_nxt;
    CDB   [C_CDB_NUM-1:0]               r_cdb;

    always_comb begin
        w_req_valid = '0;
        for (int i = 0; i < C_FU_NUM; i++) begin
            w_req_valid[i] = fu_req_i[i].valid;
        end
    end

    rr_pick #(
        .C_FU_NUM  (C_FU_NUM),
        .C_CDB_NUM (C_CDB_NUM),
        .C_PTR_W   (C_PTR_W)
    ) u_rr_pick (
        .i_req   (w_req_valid),
        .i_start (w_start),
        .o_grant (w_grant)
    );

`ifdef CDB_ARB_RR_EN
    logic [C_PTR_W-1:0] r_rr_ptr;
    logic [C_PTR_W-1:0] w_rr_ptr_nxt;

    // Channels fill in scan order, so the highest occupied channel holds the last grant.
    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        for (int k = 0; k < C_CDB_NUM; k++) begin
            for (int i = 0; i < C_FU_NUM; i++) begin
                if (w_grant[k][i]) begin
                    w_rr_ptr_nxt = (i == C_FU_NUM - 1) ? '0 : C_PTR_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rr_ptr <= '0;
        end else if (rollback_i) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    always_comb begin
        w_ack     = '0;
        w_cdb_nxt = '0;
        for (int k = 0; k < C_CDB_NUM; k++) begin
            for (int i = 0; i < C_FU_NUM; i++) begin
                if (w_grant[k][i]) begin
                    w_cdb_nxt[k].valid = 1'b1;
                    w_cdb_nxt[k].tag   = w_cdb_nxt[k].tag | fu_req_i[i].tag;
                    w_ack[i]           = 1'b1;
                end
            end
        end
        // A squash drops this cycle's winners instead of deferring them.
        if (rollback_i) begin
            w_cdb_nxt = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cdb <= '0;
        end else begin
            r_cdb <= w_cdb_nxt;
        end
    end

    assign fu_ack_o = (rollback_i || !rst_n_i) ? '0 : w_ack;
    assign cdb_o    = r_cdb;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_cdb_arbiter: directed vector table plus reset corner sequences for     |
// | cdb_arbiter at 4 FUs / 2 channels, in either arbitration mode.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cdb_arbiter;
    import sys_defs::*;

`ifdef CDB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             rollback;
    FU_CDB [3:0]      req;
    logic  [3:0]      ack;
    CDB    [1:0]      cdb;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(
        .C_FU_NUM        (4),
        .C_CDB_NUM       (2),
        .C_TAG_IDX_WIDTH (TAG_IDX_WIDTH)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rollback_i (rollback),
        .fu_req_i   (req),
        .fu_ack_o   (ack),
        .cdb_o      (cdb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            rb;
        logic [3:0]      v;
        logic [3:0][5:0] tag;
        logic [3:0]      ack;
        logic            v0;
        logic [5:0]      t0;
        logic            v1;
        logic [5:0]      t1;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rb, input logic [3:0] v, input logic [3:0][5:0] t);
        rollback = rb;
        for (int i = 0; i < 4; i++) begin
            req[i].valid = v[i];
            req[i].tag   = t[i];
        end
    endtask

    task automatic check_cdb(input string name, input int ch, input logic ev, input logic [5:0] et);
        logic [6:0] act;
        logic [6:0] exp;
        act = {cdb[ch].valid, cdb[ch].valid ? cdb[ch].tag : 6'd0};
        exp = {ev, ev ? et : 6'd0};
        check(name, 32'(act), 32'(exp));
    endtask

    function automatic vec_t mk(input logic rb, input logic [3:0] v, input logic [3:0][5:0] t,
                                input logic [3:0] a, input logic v0, input logic [5:0] t0,
                                input logic v1, input logic [5:0] t1);
        vec_t r;
        r.rb = rb; r.v = v; r.tag = t; r.ack = a;
        r.v0 = v0; r.t0 = t0; r.v1 = v1; r.t1 = t1;
        return r;
    endfunction

    localparam logic [3:0][5:0] T4567 = {6'd7, 6'd6, 6'd5, 6'd4};

    initial begin
        vecs[0]  = mk(0, 4'b0010, {6'd0, 6'd0, 6'd9, 6'd0}, 4'b0010, 1, 9, 0, 0);
        vecs[1]  = mk(1, 4'b0100, {6'd0, 6'd12, 6'd0, 6'd0}, 4'b0000, 0, 0, 0, 0);
        vecs[2]  = mk(0, 4'b1111, T4567, 4'b0011, 1, 4, 1, 5);
        vecs[3]  = RR ? mk(0, 4'b1111, T4567, 4'b1100, 1, 6, 1, 7)
                      : mk(0, 4'b1111, T4567, 4'b0011, 1, 4, 1, 5);
        vecs[4]  = mk(0, 4'b1111, T4567, 4'b0011, 1, 4, 1, 5);
        vecs[5]  = mk(0, 4'b0100, {6'd0, 6'd12, 6'd0, 6'd0}, 4'b0100, 1, 12, 0, 0);
        vecs[6]  = RR ? mk(0, 4'b1001, {6'd3, 6'd0, 6'd0, 6'd1}, 4'b1001, 1, 3, 1, 1)
                      : mk(0, 4'b1001, {6'd3, 6'd0, 6'd0, 6'd1}, 4'b1001, 1, 1, 1, 3);
        vecs[7]  = RR ? mk(0, 4'b1111, T4567, 4'b0110, 1, 5, 1, 6)
                      : mk(0, 4'b1111, T4567, 4'b0011, 1, 4, 1, 5);
        vecs[8]  = RR ? mk(0, 4'b1111, T4567, 4'b1001, 1, 7, 1, 4)
                      : mk(0, 4'b1111, T4567, 4'b0011, 1, 4, 1, 5);
        vecs[9]  = mk(0, 4'b1010, {6'd21, 6'd0, 6'd20, 6'd0}, 4'b1010, 1, 20, 1, 21);
        vecs[10] = mk(0, 4'b1101, {6'd30, 6'd31, 6'd0, 6'd32}, 4'b0101, 1, 32, 1, 31);
        vecs[11] = mk(0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd40}, 4'b0001, 1, 40, 0, 0);
        vecs[12] = mk(1, 4'b1111, T4567, 4'b0000, 0, 0, 0, 0);
        vecs[13] = mk(0, 4'b1111, T4567, 4'b0011, 1, 4, 1, 5);

        // Reset state with requests already pending.
        rst_n = 1'b0;
        drive(0, 4'b1111, T4567);
        #1;
        check("reset_ack", 32'(ack), 32'h0);
        @(posedge clk); #1;
        check_cdb("reset_cdb0", 0, 0, 0);
        check_cdb("reset_cdb1", 1, 0, 0);
        check("reset_tags", 32'({cdb[1].tag, cdb[0].tag}), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 14; n++) begin
            if (n != 0) @(negedge clk);
            drive(vecs[n].rb, vecs[n].v, vecs[n].tag);
            #1;
            check($sformatf("vec%0d_ack", n), 32'(ack), 32'(vecs[n].ack));
            @(posedge clk); #1;
            check_cdb($sformatf("vec%0d_cdb0", n), 0, vecs[n].v0, vecs[n].t0);
            check_cdb($sformatf("vec%0d_cdb1", n), 1, vecs[n].v1, vecs[n].t1);
        end

        // Asynchronous reset between edges while a broadcast is live.
        @(negedge clk);
        drive(0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd50});
        @(posedge clk); #1;
        check_cdb("pre_async_cdb0", 0, 1, 50);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'({cdb[1].valid, cdb[0].valid}), 32'h0);
        check("async_rst_tag0", 32'(cdb[0].tag), 32'h0);
        check("async_rst_ack", 32'(ack), 32'h0);

        // Release mid-request: scan restarts at FU0.
        @(negedge clk);
        drive(0, 4'b1111, T4567);
        rst_n = 1'b1;
        #1;
        check("post_rst_ack", 32'(ack), 32'b0011);
        @(posedge clk); #1;
        check_cdb("post_rst_cdb0", 0, 1, 4);
        check_cdb("post_rst_cdb1", 1, 1, 5);
        @(negedge clk); #1;
        check("post_rst_ack2", 32'(ack), RR ? 32'b1100 : 32'b0011);
        @(posedge clk); #1;
        check_cdb("post_rst2_cdb0", 0, 1, RR ? 6'd6 : 6'd4);
        @(negedge clk); #1;
        check("post_rst_ack3", 32'(ack), 32'b0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter C_FU_NUM, default `FU_NUM, number of functional-unit completion requesters.
REQ-002 Parameter C_CDB_NUM, default `CDB_NUM, number of CDB broadcast channels.
REQ-003 Parameter C_TAG_IDX_WIDTH, default `TAG_IDX_WIDTH, physical tag width.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 rollback_i  input  1  squash: drop pending broadcasts and restore arbitration state.
REQ-007 fu_req_i  input  FU_CDB[C_FU_NUM]  per-FU {valid, tag} completion request.
REQ-008 fu_ack_o  output  C_FU_NUM  per-FU grant; request consumed on the cycle ack is high.
REQ-009 cdb_o  output  CDB[C_CDB_NUM]  registered {valid, tag} broadcast to map table, RS and ROB.

Function
REQ-010 Each cycle, up to C_CDB_NUM valid requests are granted; fu_ack_o is combinational from fu_req_i and the arbitration pointer.
REQ-011 fu_ack_o[i] is never high when fu_req_i[i].valid is low.
REQ-012 An FU holds valid and tag stable until acked; the arbiter requires no other handshake signal.
REQ-013 Grants are assigned in round-robin order, scanning from pointer rr_ptr upward with wrap at C_FU_NUM-1 -> 0.
REQ-014 The k-th granted FU in scan order drives CDB channel k; unused channels carry valid=0.
REQ-015 Granted requests appear on cdb_o exactly one cycle after ack (latency 1); cdb_o is a pure register output.
REQ-016 rr_ptr update: when at least one grant, rr_ptr <= (index of last granted FU + 1) mod C_FU_NUM; when no grant, rr_ptr holds.
REQ-017 Fewer valid requests than C_CDB_NUM: all granted same cycle, no FU waits.
REQ-018 More valid requests than C_CDB_NUM: exactly C_CDB_NUM granted, rest see ack=0 and retry next cycle.
REQ-019 Starvation bound: a continuously valid FU is acked within ceil(C_FU_NUM / C_CDB_NUM) cycles.
REQ-020 Tag on each valid cdb_o channel equals the acked FU's tag; two channels never broadcast in the same cycle from the same FU.
REQ-021 rollback_i high: fu_ack_o forced to all-zero that cycle; cdb_o valid all cleared next cycle; rr_ptr reset to 0.
REQ-022 rollback_i has priority over any concurrent request; requests present during rollback are dropped, not delayed.
REQ-023 Cycle after rollback_i deasserts: normal arbitration resumes from rr_ptr=0.

Reset
REQ-024 On rst_n_i low, asynchronously: all cdb_o[k].valid=0, all cdb_o[k].tag=0, rr_ptr=0.
REQ-025 While rst_n_i is low, fu_ack_o is all-zero.
REQ-026 Reset deasserted mid-request: first grant occurs on the first rising edge with rst_n_i high, scanning from FU 0.

Configuration
REQ-027 Macro CDB_ARB_RR_EN defined: round-robin per REQ-013/016/019.
REQ-028 Macro CDB_ARB_RR_EN undefined: fixed priority, lowest FU index wins, rr_ptr register removed, REQ-019 waived; all other requirements unchanged.

Structure
REQ-029 FU_CDB struct, existing CDB struct, FU_NUM and CDB_NUM belong in the shared sys_defs package; nothing local to the module.
REQ-030 One sub-module, rr_pick: C_FU_NUM request vector + start pointer -> first C_CDB_NUM granted one-hot indices; instantiated once.

Verification (C_FU_NUM=4, C_CDB_NUM=2, RR enabled)
REQ-031 Reset release, FU1 valid tag=9 -> fu_ack_o=0010 same cycle; next cycle cdb_o[0]={1,9}, cdb_o[1].valid=0.
REQ-032 All 4 FUs valid held, tags 4,5,6,7 -> acks 0011, 1100, 0011 on successive cycles; cdb_o tags (4,5),(6,7),(4,5).
REQ-033 FU0 and FU3 valid, rr_ptr=3 -> ack 1001; cdb_o[0].tag=FU3 tag, cdb_o[1].tag=FU0 tag; rr_ptr becomes 1.
REQ-034 FU2 tag=12 valid with rollback_i=1 -> fu_ack_o=0000; next cycle all cdb_o valid=0, rr_ptr=0.
REQ-035 rst_n_i pulled low between clock edges while cdb_o valid -> cdb_o valid drops before next edge.
REQ-036 CDB_ARB_RR_EN undefined, all 4 FUs held valid 3 cycles -> ack 0011 every cycle, FU2/FU3 never acked.
